// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
// rsp_t carries an ovf field only when ADDER_SHARE_OVF_EN is defined.
package adder_share_pkg;

    localparam int DATA_W   = 64;
    localparam int ID_MAX_W = 4;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // The id field is sized for the largest legal NREQ and sliced by the top.
    typedef struct packed {
        logic [DATA_W-1:0]   sum;
        logic                cout;
        logic [ID_MAX_W-1:0] id;
`ifdef ADDER_SHARE_OVF_EN
        logic                ovf;
`endif
    } rsp_t;

    function automatic logic [ID_MAX_W-1:0] rr_next(input logic [ID_MAX_W-1:0] ptr,
                                                    input int nreq);
        logic [ID_MAX_W-1:0] nxt;
        if (int'(ptr) >= nreq - 1) begin
            nxt = 4'd0;
        end else begin
            nxt = ptr + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/adder_64.sv
// 64-bit ripple-carry adder shared by the matrix-multiply datapath.
module adder_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    logic [64:0] carry_s;

    // Bit-serial ripple of the carry from bit 0 to bit 63.
    always_comb begin
        carry_s    = 65'd0;
        sum        = 64'd0;
        carry_s[0] = cin;
        for (int i = 0; i < 64; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
        cout = carry_s[64];
    end

endmodule

// File: rtl/adder_share_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module adder_share_rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx,
    output logic            any_req
);

    logic hit_s;

    // Upper pass covers [ptr, NREQ-1]; lower pass covers the wrap [0, ptr-1].
    always_comb begin
        gnt     = {NREQ{1'b0}};
        idx     = {ID_W{1'b0}};
        any_req = 1'b0;
        hit_s   = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            hit_s   = req[j] & (j >= int'(ptr)) & ~any_req;
            gnt[j]  = gnt[j] | hit_s;
            idx     = hit_s ? ID_W'(j) : idx;
            any_req = any_req | hit_s;
        end
        for (int j = 0; j < NREQ; j++) begin
            hit_s   = req[j] & (j < int'(ptr)) & ~any_req;
            gnt[j]  = gnt[j] | hit_s;
            idx     = hit_s ? ID_W'(j) : idx;
            any_req = any_req | hit_s;
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one adder_64 among NREQ requesters, with a
// one-entry response register. Define ADDER_SHARE_OVF_EN to add rsp_ovf.
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
    output logic [DATA_W-1:0]      rsp_sum,
    output logic                   rsp_cout
`ifdef ADDER_SHARE_OVF_EN
    ,
    output logic                   rsp_ovf
`endif
);

    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    rsp_state_e        state_r, state_nxt_s;
    rsp_t              rsp_r, rsp_nxt_s;
    logic [ID_W-1:0]   ptr_r, ptr_nxt_s;
    logic              acc_en_s;
    logic [NREQ-1:0]   pick_req_s;
    logic [NREQ-1:0]   gnt_s;
    logic [ID_W-1:0]   gnt_idx_s;
    logic              any_gnt_s;
    logic [DATA_W-1:0] a_mux_s, b_mux_s, sum_s;
    logic              cout_s;
    logic              id_unused_s;

    // A response drained this cycle frees the slot for a same-cycle accept.
    assign acc_en_s   = (state_r == RSP_EMPTY) | rsp_ready;
    assign pick_req_s = (acc_en_s & ~rst) ? req_valid : {NREQ{1'b0}};
    assign req_ready  = gnt_s;

    adder_share_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req     (pick_req_s),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .idx     (gnt_idx_s),
        .any_req (any_gnt_s)
    );

    // One-hot AND-OR operand mux driven directly by the grant vector.
    always_comb begin
        a_mux_s = {DATA_W{1'b0}};
        b_mux_s = {DATA_W{1'b0}};
        for (int j = 0; j < NREQ; j++) begin
            a_mux_s = a_mux_s | (req_a[j*DATA_W +: DATA_W] & {DATA_W{gnt_s[j]}});
            b_mux_s = b_mux_s | (req_b[j*DATA_W +: DATA_W] & {DATA_W{gnt_s[j]}});
        end
    end

    adder_64 u_adder (
        .a    (a_mux_s),
        .b    (b_mux_s),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Response-slot next state, captured fields and pointer advance.
    always_comb begin
        state_nxt_s = state_r;
        rsp_nxt_s   = rsp_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            RSP_EMPTY: begin
                if (any_gnt_s) begin
                    state_nxt_s = RSP_FULL;
                end else begin
                    state_nxt_s = RSP_EMPTY;
                end
            end
            RSP_FULL: begin
                if (any_gnt_s) begin
                    state_nxt_s = RSP_FULL;
                end else if (rsp_ready) begin
                    state_nxt_s = RSP_EMPTY;
                end else begin
                    state_nxt_s = RSP_FULL;
                end
            end
            default: begin
                state_nxt_s = RSP_EMPTY;
            end
        endcase
        if (any_gnt_s) begin
            rsp_nxt_s.sum  = sum_s;
            rsp_nxt_s.cout = cout_s;
            rsp_nxt_s.id   = ID_MAX_W'(gnt_idx_s);
`ifdef ADDER_SHARE_OVF_EN
            rsp_nxt_s.ovf  = (a_mux_s[DATA_W-1] == b_mux_s[DATA_W-1]) &
                             (sum_s[DATA_W-1] != a_mux_s[DATA_W-1]);
`endif
            ptr_nxt_s      = ID_W'(rr_next(ID_MAX_W'(gnt_idx_s), NREQ));
        end else begin
            rsp_nxt_s = rsp_r;
            ptr_nxt_s = ptr_r;
        end
    end

    // State, response and pointer registers; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RSP_EMPTY;
            rsp_r   <= {$bits(rsp_t){1'b0}};
            ptr_r   <= {ID_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            rsp_r   <= rsp_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    assign rsp_valid   = (state_r == RSP_FULL);
    assign rsp_sum     = rsp_r.sum;
    assign rsp_cout    = rsp_r.cout;
    assign rsp_id      = rsp_r.id[ID_W-1:0];
    assign id_unused_s = ^rsp_r.id;
`ifdef ADDER_SHARE_OVF_EN
    assign rsp_ovf     = rsp_r.ovf;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboard bench for adder_share_arb (NREQ = 4).
module tb_adder_share_arb;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [255:0] req_a, req_b;
    logic [63:0]  op_a [4];
    logic [63:0]  op_b [4];
    logic         rsp_valid, rsp_ready, rsp_cout;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_sum;
`ifdef ADDER_SHARE_OVF_EN
    logic         rsp_ovf;
`endif

    exp_t       sb[$];
    logic       m_valid;
    logic [1:0] m_ptr;
    int         n_checks = 0;
    int         n_fail   = 0;

    assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

    always #5 clk = ~clk;

    adder_share_arb #(.NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef ADDER_SHARE_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 2'd0;
        sb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 4'b0000; rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Drives one cycle, predicts the grant, updates the scoreboard, steps past the edge.
    task automatic cycle(input logic [3:0] v, input logic rr,
                         output logic [3:0] obs, output logic [3:0] exp_rdy);
        exp_t        e;
        int          g;
        int          idx;
        logic [64:0] full;
        req_valid = v; rsp_ready = rr;
        #1;
        obs = req_ready;
        g   = -1;
        if (!m_valid || rr) begin
            for (int k = 0; k < 4; k++) begin
                idx = (int'(m_ptr) + k) % 4;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        if (m_valid && rr) void'(sb.pop_front());
        if (g >= 0) begin
            full   = {1'b0, op_a[g]} + {1'b0, op_b[g]};
            e.id   = 2'(g);
            e.sum  = full[63:0];
            e.cout = full[64];
            e.ovf  = (op_a[g][63] == op_b[g][63]) && (full[63] != op_a[g][63]);
            sb.push_back(e);
            m_valid = 1'b1;
            m_ptr   = 2'((g + 1) % 4);
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_pre: got %b want 0000", req_ready); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        rst = 1'b0; req_valid = 4'b0000;
        model_reset();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== 68'd0)
            begin n_fail++; $display("FAIL reset_rsp: got v=%b id=%0d sum=%h c=%b want all 0", rsp_valid, rsp_id, rsp_sum, rsp_cout); end
`ifdef ADDER_SHARE_OVF_EN
        n_checks++;
        if (rsp_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", rsp_ovf); end
`endif
    endtask

    task automatic test_single();
        logic [3:0] obs, exp_rdy;
        op_a[2] = 64'd5; op_b[2] = 64'd7;
        cycle(4'b0100, 1'b1, obs, exp_rdy);
        n_checks++;
        if (obs !== exp_rdy) begin n_fail++; $display("FAIL single_ready: got %b want %b", obs, exp_rdy); end
        n_checks++;
        if (rsp_valid !== m_valid) begin n_fail++; $display("FAIL single_valid: got %b want %b", rsp_valid, m_valid); end
        if (m_valid) begin
            n_checks++;
            if (rsp_id !== sb[0].id || rsp_sum !== sb[0].sum || rsp_cout !== sb[0].cout)
                begin n_fail++; $display("FAIL single_rsp: got id=%0d sum=%0d c=%b want id=%0d sum=%0d c=%b", rsp_id, rsp_sum, rsp_cout, sb[0].id, sb[0].sum, sb[0].cout); end
        end
        cycle(4'b0000, 1'b1, obs, exp_rdy);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got valid %b want 0", rsp_valid); end
    endtask

    task automatic test_carry();
        logic [3:0] obs, exp_rdy;
        op_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; op_b[0] = 64'd1;
        cycle(4'b0001, 1'b1, obs, exp_rdy);
        n_checks++;
        if (obs !== exp_rdy) begin n_fail++; $display("FAIL carry_ready: got %b want %b", obs, exp_rdy); end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 64'd0 || rsp_cout !== 1'b1 || rsp_id !== 2'd0)
            begin n_fail++; $display("FAIL carry_wrap: got v=%b id=%0d sum=%h c=%b want v=1 id=0 sum=0 c=1", rsp_valid, rsp_id, rsp_sum, rsp_cout); end
`ifdef ADDER_SHARE_OVF_EN
        n_checks++;
        if (rsp_ovf !== 1'b0) begin n_fail++; $display("FAIL carry_no_ovf: got %b want 0", rsp_ovf); end
        op_a[1] = 64'h7FFF_FFFF_FFFF_FFFF; op_b[1] = 64'd1;
        cycle(4'b0010, 1'b1, obs, exp_rdy);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_ovf !== sb[0].ovf || rsp_ovf !== 1'b1 || rsp_sum !== sb[0].sum)
            begin n_fail++; $display("FAIL carry_ovf: got v=%b ovf=%b sum=%h want v=1 ovf=1 sum=%h", rsp_valid, rsp_ovf, rsp_sum, sb[0].sum); end
`endif
        cycle(4'b0000, 1'b1, obs, exp_rdy);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL carry_drain: got valid %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] obs, exp_rdy;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            op_a[i] = {$urandom, $urandom};
            op_b[i] = {$urandom, $urandom};
        end
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, 1'b1, obs, exp_rdy);
            n_checks++;
            if (obs !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", i, obs, exp_rdy); end
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(i % 4))
                begin n_fail++; $display("FAIL rr_id[%0d]: got v=%b id=%0d want v=1 id=%0d", i, rsp_valid, rsp_id, i % 4); end
            n_checks++;
            if (rsp_sum !== sb[0].sum || rsp_cout !== sb[0].cout)
                begin n_fail++; $display("FAIL rr_sum[%0d]: got %h/%b want %h/%b", i, rsp_sum, rsp_cout, sb[0].sum, sb[0].cout); end
        end
        cycle(4'b0000, 1'b1, obs, exp_rdy);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got valid %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        logic [3:0] obs, exp_rdy;
        cycle(4'b1111, 1'b1, obs, exp_rdy);
        n_checks++;
        if (obs !== exp_rdy || obs !== 4'b0100) begin n_fail++; $display("FAIL bp_first: got %b want %b", obs, exp_rdy); end
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, 1'b0, obs, exp_rdy);
            n_checks++;
            if (obs !== 4'b0000 || exp_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", i, obs); end
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== sb[0].id || rsp_sum !== sb[0].sum || rsp_cout !== sb[0].cout)
                begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h", i, rsp_valid, rsp_id, rsp_sum, sb[0].id, sb[0].sum); end
        end
        cycle(4'b1111, 1'b1, obs, exp_rdy);
        n_checks++;
        if (obs !== exp_rdy || obs !== 4'b1000) begin n_fail++; $display("FAIL bp_resume: got %b want %b", obs, exp_rdy); end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== sb[0].id || rsp_sum !== sb[0].sum)
            begin n_fail++; $display("FAIL bp_next_rsp: got id=%0d sum=%h want id=%0d sum=%h", rsp_id, rsp_sum, sb[0].id, sb[0].sum); end
        cycle(4'b0000, 1'b1, obs, exp_rdy);
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs, exp_rdy;
        op_a[2] = 64'h1000; op_b[2] = 64'h0234;
        cycle(4'b0100, 1'b0, obs, exp_rdy);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 64'h1234 || rsp_id !== 2'd2)
            begin n_fail++; $display("FAIL mid_load: got v=%b sum=%h id=%0d want v=1 sum=1234 id=2", rsp_valid, rsp_sum, rsp_id); end
        rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 64'd0)
            begin n_fail++; $display("FAIL mid_cleared: got v=%b sum=%h want v=0 sum=0", rsp_valid, rsp_sum); end
        cycle(4'b1111, 1'b1, obs, exp_rdy);
        n_checks++;
        if (obs !== exp_rdy || obs !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0001", obs); end
        cycle(4'b0000, 1'b1, obs, exp_rdy);
    endtask

    task automatic test_sparse();
        logic [3:0] obs, exp_rdy;
        logic [3:0] want [3];
        want[0] = 4'b1000; want[1] = 4'b0010; want[2] = 4'b1000;
        cycle(4'b0010, 1'b1, obs, exp_rdy);
        n_checks++;
        if (obs !== 4'b0010) begin n_fail++; $display("FAIL sparse_setup: got %b want 0010", obs); end
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1010, 1'b1, obs, exp_rdy);
            n_checks++;
            if (obs !== exp_rdy || obs !== want[i]) begin n_fail++; $display("FAIL sparse_grant[%0d]: got %b want %b", i, obs, want[i]); end
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== sb[0].id || rsp_sum !== sb[0].sum)
                begin n_fail++; $display("FAIL sparse_rsp[%0d]: got id=%0d sum=%h want id=%0d sum=%h", i, rsp_id, rsp_sum, sb[0].id, sb[0].sum); end
        end
        cycle(4'b0000, 1'b1, obs, exp_rdy);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sparse_drain: got valid %b want 0", rsp_valid); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'b0000; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = 64'd0;
            op_b[i] = 64'd0;
        end
        model_reset();
        test_reset();
        test_single();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_sparse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter and sequencer that shares one `adder_64` instance among NREQ requesters in the matrix-multiply datapath. Each requester presents a 64-bit operand pair under a valid/ready handshake. The arbiter grants one requester per cycle, registers the sum, carry and requester ID in a one-entry response stage, and returns them under a second valid/ready handshake. The block sits between the partial-product producers and the accumulation stage.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; legal range is 1..16.
- `ID_W`, default `$clog2(NREQ)` with a minimum of 1: width of the response ID. This is a localparam.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, NREQ: per-requester operand valid.
- `req_a`, input, NREQ*64: operand A; requester i occupies bits [64i+63:64i].
- `req_b`, input, NREQ*64: operand B, packed the same way as `req_a`.
- `req_ready`, output, NREQ: one-hot grant; all zero when nothing is accepted.
- `rsp_valid`, output, 1: the response register is full.
- `rsp_ready`, input, 1: downstream accepts the response.
- `rsp_id`, output, ID_W: index of the requester that produced this response.
- `rsp_sum`, output, 64: `a + b` modulo 2^64.
- `rsp_cout`, output, 1: carry out of bit 63.
- `rsp_ovf`, output, 1: signed overflow. This port exists only when `ADDER_SHARE_OVF_EN` is defined.

## Operation
- **State.**
  - `ptr` is the round-robin priority pointer, of width ID_W.
  - The response register has two states: EMPTY (`rsp_valid` = 0) and FULL (`rsp_valid` = 1).
- **Accept enable.** `acc_en = !rsp_valid | rsp_ready`. A response drained in the same cycle frees the slot, which gives one operation per cycle at full throughput.
- **Grant.**
  - When `acc_en` is high and any `req_valid` bit is set, grant the first valid requester found searching upward from `ptr`, wrapping modulo NREQ.
  - `req_ready[g]` = 1 for the granted index only.
  - `req_ready` is combinational from `req_valid`, `ptr` and `rsp_valid`/`rsp_ready`.
  - A requester must hold `req_valid` and its operands until it sees `req_ready`.
- **On accept (edge at the end of the grant cycle):**
  - `rsp_sum` and `rsp_cout` take the outputs of `adder_64` driven by the muxed `req_a[g]` and `req_b[g]`.
  - `rsp_id` = g.
  - `rsp_valid` = 1.
  - `ptr` = (g+1) mod NREQ.
- **No accept while draining:** if `rsp_valid & rsp_ready` and there is no new grant, the register goes EMPTY (`rsp_valid` = 0). Data fields hold their old values.
- **Stall:** when `rsp_valid & !rsp_ready`, all `rsp_*` outputs and `ptr` hold stable and `req_ready` is all zero.
- **Fairness:** `ptr` advances only on an accept. No requester waits more than NREQ-1 grants once it is valid.
- **Arithmetic:**
  - Unsigned, wraps modulo 2^64.
  - 0xFFFF_FFFF_FFFF_FFFF + 1 gives sum 0 with cout 1.
- **Reset (synchronous):**
  - `rsp_valid` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `rsp_id` = 0, `ptr` = 0, `rsp_ovf` = 0.
  - A result pending at reset is discarded.
  - `req_ready` is 0 while `rst` is high.

## Timing
- Latency is 1 cycle: operands accepted at edge N appear on `rsp_*` with `rsp_valid` = 1 after edge N.
- Throughput is 1 result per cycle while `rsp_ready` = 1.
- Critical path: operand mux, then the 64-bit ripple carry in `adder_64`, then the response register. There are no internal pipeline stages.
- `req_ready` has a combinational path from `rsp_ready`. Downstream logic must not make `rsp_ready` depend on `req_ready`.

## Configuration
- `ADDER_SHARE_OVF_EN` defined:
  - The `rsp_ovf` port is present.
  - It is registered on accept as `(a[63] == b[63]) & (sum[63] != a[63])`.
  - It resets to 0 and holds during stalls, like the other `rsp_*` fields.
- `ADDER_SHARE_OVF_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `adder_share_pkg`:
  - `localparam DATA_W = 64`.
  - typedef `rsp_t` containing the sum, cout, id and (conditionally) ovf fields.
  - Function `rr_next(ptr, NREQ)`.
- Datapath: one instance of the existing `adder_64`.
- One new sub-module, `adder_share_rr_pick`: a combinational round-robin priority picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, grant index and `any` flag.

## Test plan
- **Single request:** after reset, requester 2 presents a = 5, b = 7 with `rsp_ready` = 1. Expect `req_ready` = 0100, then the next cycle `rsp_valid` = 1, `rsp_sum` = 12, `rsp_id` = 2, `rsp_cout` = 0.
- **Carry wrap:** a = 0xFFFF_FFFF_FFFF_FFFF, b = 1. Expect `rsp_sum` = 0 and `rsp_cout` = 1. With OVF_EN, a = 0x7FFF_FFFF_FFFF_FFFF, b = 1 gives `rsp_ovf` = 1.
- **Round robin:** all 4 requesters continuously valid with `rsp_ready` = 1. Expect the `rsp_id` sequence 0,1,2,3,0,1 on back-to-back cycles with no bubbles.
- **Backpressure:** hold `rsp_ready` = 0 for 3 cycles while requests are pending. Expect `rsp_*` stable, `req_ready` = 0 and `ptr` frozen; the next grant occurs in the cycle `rsp_ready` returns to 1.
- **Reset mid-operation:** assert `rst` while `rsp_valid` = 1 and `rsp_sum` = 0x1234. Expect `rsp_valid` = 0 and `rsp_sum` = 0 after the edge, and the first grant after reset goes to requester 0.
- **Sparse fairness:** requesters 1 and 3 valid, `ptr` = 2. Expect grant 3, then grant 1, then grant 3.
